// File: rtl/croc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : croc_pkg
// Purpose  : Shared types and constants for the croc SoC fabric. Holds the
//            subordinate-side OBI request/response structs, the regbus
//            request/response structs and the regbus bridge timeout default.
// Revision : 1.0 - initial release
// ============================================================================
package croc_pkg;

  // Subordinate-side OBI configuration (only the fields used here)
  typedef struct packed {
    int unsigned IdWidth;
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam int unsigned SbrObiIdWidth = 4;
  localparam obi_cfg_t SbrObiCfg = '{IdWidth: SbrObiIdWidth, AddrWidth: 32, DataWidth: 32};

  // Default regbus watchdog length for the OBI-to-regbus bridge
  localparam int unsigned RegBridgeTimeout = 256;

  typedef struct packed {
    logic [31:0]              addr;
    logic                     we;
    logic [3:0]               be;
    logic [31:0]              wdata;
    logic [SbrObiIdWidth-1:0] aid;
    logic                     a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]              rdata;
    logic [SbrObiIdWidth-1:0] rid;
    logic                     err;
    logic                     r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage
`default_nettype wire

// File: rtl/croc_obi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : croc_obi_reg_bridge
// Purpose  : OBI subordinate that turns one OBI transaction at a time into a
//            regbus access, returning rdata/err with the matching rid. A
//            watchdog aborts regbus accesses that never see ready.
// Ports    : clk_i     - clock, rising edge
//            rst_i     - synchronous reset, active-high
//            obi_req_i - OBI request from the interconnect
//            obi_rsp_o - OBI response (gnt, rvalid, r.rdata/rid/err)
//            reg_req_o - regbus request to the peripheral
//            reg_rsp_i - regbus response from the peripheral
//            busy_o    - high whenever a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module croc_obi_reg_bridge
  import croc_pkg::*;
#(
  parameter type         obi_req_t     = sbr_obi_req_t,
  parameter type         obi_rsp_t     = sbr_obi_rsp_t,
  parameter type         reg_req_t     = croc_pkg::reg_req_t,
  parameter type         reg_rsp_t     = croc_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = RegBridgeTimeout
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  output logic     busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Counter width keeps at least one bit so a disabled watchdog still elaborates
  localparam int unsigned   CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  state_e r_state, w_state_next;

  logic [31:0]                        r_addr;
  logic                               r_we;
  logic [3:0]                         r_be;
  logic [31:0]                        r_wdata;
  logic [$bits(obi_req_i.a.aid)-1:0]  r_aid;
  logic [31:0]                        r_rdata;
  logic                               r_err;
  logic [CntW-1:0]                    r_cnt;

  logic w_gnt;
  logic w_capture;
  logic w_timeout;
  logic w_unused_a_optional;

  assign w_unused_a_optional = obi_req_i.a.a_optional;

  always_comb begin
    w_state_next = r_state;
    w_gnt        = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        // Never grant during reset: the request would be lost when reset wins.
        w_gnt = obi_req_i.req & ~rst_i;
        if (w_gnt) w_state_next = ACCESS;
      end
      ACCESS: begin
        // Ready takes priority over the watchdog on the expiry cycle.
        if (reg_rsp_i.ready) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end else if ((TimeoutCycles != 0) && (r_cnt == CntLast)) begin
          w_timeout    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_gnt        = obi_req_i.req & ~rst_i;
        w_state_next = w_gnt ? ACCESS : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_aid   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_gnt) begin
        r_addr  <= obi_req_i.a.addr;
        r_we    <= obi_req_i.a.we;
        r_be    <= obi_req_i.a.be;
        r_wdata <= obi_req_i.a.wdata;
        r_aid   <= obi_req_i.a.aid;
        r_cnt   <= '0;
      end else if ((r_state == ACCESS) && !reg_rsp_i.ready) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_capture) begin
        // Writes and failed accesses never return peripheral data.
        r_rdata <= (r_we || reg_rsp_i.error) ? 32'h0 : reg_rsp_i.rdata;
        r_err   <= reg_rsp_i.error;
      end else if (w_timeout) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end
    end
  end

  always_comb begin
    obi_rsp_o     = '0;
    obi_rsp_o.gnt = w_gnt;
    if (r_state == RESP) begin
      obi_rsp_o.rvalid  = 1'b1;
      obi_rsp_o.r.rdata = r_rdata;
      obi_rsp_o.r.rid   = r_aid;
      obi_rsp_o.r.err   = r_err;
    end
  end

  // Regbus fields are zero outside ACCESS so only valid ever needs decoding.
  always_comb begin
    reg_req_o = '0;
    if (r_state == ACCESS) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.addr  = r_addr;
      reg_req_o.write = r_we;
      reg_req_o.wdata = r_wdata;
      reg_req_o.wstrb = r_be;
    end
  end

  assign busy_o = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_croc_obi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_croc_obi_reg_bridge
// Purpose  : Directed self-checking bench for croc_obi_reg_bridge with an
//            8-cycle regbus watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_croc_obi_reg_bridge;
  import croc_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  croc_obi_reg_bridge #(
    .TimeoutCycles(8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .obi_req_i(obi_req),
    .obi_rsp_o(obi_rsp),
    .reg_req_o(reg_req),
    .reg_rsp_i(reg_rsp),
    .busy_o   (busy)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic r, input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd, input logic [3:0] aid);
    obi_req         = '0;
    obi_req.req     = r;
    obi_req.a.addr  = a;
    obi_req.a.we    = we;
    obi_req.a.be    = be;
    obi_req.a.wdata = wd;
    obi_req.a.aid   = aid;
  endtask

  task automatic drive_rsp(input logic rdy, input logic err, input logic [31:0] rd);
    reg_rsp.ready = rdy;
    reg_rsp.error = err;
    reg_rsp.rdata = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] aids [4];
    int stable;
    int nvalid;
    int guard;
    int seen;
    aids[0] = 4'd9; aids[1] = 4'd2; aids[2] = 4'd15; aids[3] = 4'd6;

    rst = 1'b1;
    drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    drive_rsp(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk1("reset_rvalid", obi_rsp.rvalid, 1'b0);
    chk1("reset_gnt", obi_rsp.gnt, 1'b0);
    chk1("reset_valid", reg_req.valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);

    // Single read, ready in the first ACCESS cycle
    step(); drive_req(1'b1, 32'h0300_2004, 1'b0, 4'hF, 32'h0, 4'd3); #1;
    chk1("rd_gnt", obi_rsp.gnt, 1'b1);
    chk1("rd_busy_idle", busy, 1'b0);
    step(); drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0); drive_rsp(1'b1, 1'b0, 32'hDEAD_BEEF); #1;
    chk1("rd_valid", reg_req.valid, 1'b1);
    chk32("rd_addr", reg_req.addr, 32'h0300_2004);
    chk1("rd_write", reg_req.write, 1'b0);
    chk1("rd_gnt_access", obi_rsp.gnt, 1'b0);
    chk1("rd_rvalid_early", obi_rsp.rvalid, 1'b0);
    step(); drive_rsp(1'b0, 1'b0, 32'h0); #1;
    chk1("rd_rvalid", obi_rsp.rvalid, 1'b1);
    chk32("rd_rdata", obi_rsp.r.rdata, 32'hDEAD_BEEF);
    chk32("rd_rid", 32'(obi_rsp.r.rid), 32'd3);
    chk1("rd_err", obi_rsp.r.err, 1'b0);
    chk1("rd_valid_resp", reg_req.valid, 1'b0);
    chk32("rd_addr_resp", reg_req.addr, 32'h0);
    step(); #1;
    chk1("rd_rvalid_once", obi_rsp.rvalid, 1'b0);
    chk1("rd_busy_done", busy, 1'b0);

    // Write with ready delayed 5 cycles
    step(); drive_req(1'b1, 32'h0300_2008, 1'b1, 4'b0011, 32'h1234_5678, 4'd5); #1;
    chk1("wr_gnt", obi_rsp.gnt, 1'b1);
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
      drive_rsp(i == 5, 1'b0, 32'hFFFF_FFFF);
      #1;
      if (reg_req.valid && reg_req.write && reg_req.addr == 32'h0300_2008 &&
          reg_req.wdata == 32'h1234_5678 && reg_req.wstrb == 4'b0011) stable++;
    end
    chk32("wr_stable_cycles", stable, 32'd6);
    chk32("wr_wstrb", 32'(reg_req.wstrb), 32'd3);
    step(); drive_rsp(1'b0, 1'b0, 32'h0); #1;
    chk1("wr_rvalid", obi_rsp.rvalid, 1'b1);
    chk32("wr_rdata", obi_rsp.r.rdata, 32'h0);
    chk1("wr_err", obi_rsp.r.err, 1'b0);
    chk32("wr_rid", 32'(obi_rsp.r.rid), 32'd5);

    // Back-to-back: request held, ready immediate
    step(); drive_req(1'b1, 32'h1000_0000, 1'b0, 4'hF, 32'h0, aids[0]); #1;
    chk1("b2b_gnt0", obi_rsp.gnt, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) drive_req(1'b1, 32'h1000_0000 + 32'(4 * (k + 1)), 1'b0, 4'hF, 32'h0, aids[k + 1]);
      else       drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
      drive_rsp(1'b1, 1'b0, 32'hA000_0000 + 32'(k));
      #1;
      chk1("b2b_valid", reg_req.valid, 1'b1);
      chk32("b2b_addr", reg_req.addr, 32'h1000_0000 + 32'(4 * k));
      step(); #1;
      chk1("b2b_rvalid", obi_rsp.rvalid, 1'b1);
      chk32("b2b_rid", 32'(obi_rsp.r.rid), 32'(aids[k]));
      chk32("b2b_rdata", obi_rsp.r.rdata, 32'hA000_0000 + 32'(k));
      chk1("b2b_gnt_resp", obi_rsp.gnt, k < 3);
    end
    drive_rsp(1'b0, 1'b0, 32'h0);
    step(); #1;
    chk1("b2b_idle_busy", busy, 1'b0);
    chk1("b2b_idle_rvalid", obi_rsp.rvalid, 1'b0);

    // Regbus error response
    step(); drive_req(1'b1, 32'h0300_3000, 1'b0, 4'hF, 32'h0, 4'd7); #1;
    chk1("err_gnt", obi_rsp.gnt, 1'b1);
    step(); drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0); drive_rsp(1'b1, 1'b1, 32'h5555_5555); #1;
    step(); drive_rsp(1'b0, 1'b0, 32'h0); #1;
    chk1("err_rvalid", obi_rsp.rvalid, 1'b1);
    chk1("err_err", obi_rsp.r.err, 1'b1);
    chk32("err_rdata", obi_rsp.r.rdata, 32'h0);
    chk32("err_rid", 32'(obi_rsp.r.rid), 32'd7);

    // Watchdog abort, ready never arrives
    step(); drive_req(1'b1, 32'h0300_4000, 1'b0, 4'hF, 32'h0, 4'd10); #1;
    chk1("to_gnt", obi_rsp.gnt, 1'b1);
    step(); drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0); #1;
    nvalid = 0;
    guard  = 0;
    while (reg_req.valid && guard < 20) begin
      nvalid++;
      guard++;
      step();
    end
    chk32("to_valid_cycles", nvalid, 32'd8);
    chk1("to_rvalid", obi_rsp.rvalid, 1'b1);
    chk1("to_err", obi_rsp.r.err, 1'b1);
    chk32("to_rdata", obi_rsp.r.rdata, 32'h0);
    chk32("to_rid", 32'(obi_rsp.r.rid), 32'd10);

    // Ready on the watchdog expiry cycle wins
    step(); drive_req(1'b1, 32'h0300_4004, 1'b0, 4'hF, 32'h0, 4'd11); #1;
    chk1("to8_gnt", obi_rsp.gnt, 1'b1);
    nvalid = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
      drive_rsp(i == 8, 1'b0, 32'h0BAD_F00D);
      #1;
      if (reg_req.valid) nvalid++;
    end
    chk32("to8_valid_cycles", nvalid, 32'd8);
    step(); drive_rsp(1'b0, 1'b0, 32'h0); #1;
    chk1("to8_rvalid", obi_rsp.rvalid, 1'b1);
    chk1("to8_err", obi_rsp.r.err, 1'b0);
    chk32("to8_rdata", obi_rsp.r.rdata, 32'h0BAD_F00D);

    // Reset while in ACCESS drops the transaction
    step(); drive_req(1'b1, 32'h0300_5000, 1'b0, 4'hF, 32'h0, 4'd12); #1;
    chk1("rst_gnt", obi_rsp.gnt, 1'b1);
    step(); drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0); #1;
    chk1("rst_valid_before", reg_req.valid, 1'b1);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk1("rst_valid_after", reg_req.valid, 1'b0);
    chk1("rst_busy_after", busy, 1'b0);
    chk1("rst_rvalid_after", obi_rsp.rvalid, 1'b0);
    seen = 0;
    repeat (4) begin
      step();
      if (obi_rsp.rvalid) seen++;
    end
    chk32("rst_no_rvalid", seen, 32'd0);
    step(); drive_req(1'b1, 32'h0300_6000, 1'b0, 4'hF, 32'h0, 4'd13); #1;
    chk1("rst_new_gnt", obi_rsp.gnt, 1'b1);
    step(); drive_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0); drive_rsp(1'b1, 1'b0, 32'hCAFE_0001); #1;
    chk32("rst_new_addr", reg_req.addr, 32'h0300_6000);
    step(); drive_rsp(1'b0, 1'b0, 32'h0); #1;
    chk1("rst_new_rvalid", obi_rsp.rvalid, 1'b1);
    chk32("rst_new_rid", 32'(obi_rsp.r.rid), 32'd13);
    chk32("rst_new_rdata", obi_rsp.r.rdata, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
